// File: rtl/video_sig_gen.sv
// Raster timing generator for the HDMI pixel path.
// Counts pixels/lines and decodes sync, draw and frame strobes.
module video_sig_gen #(
  parameter int ACTIVE_H_PIXELS = 1280,
  parameter int H_FRONT_PORCH   = 110,
  parameter int H_SYNC_WIDTH    = 40,
  parameter int H_BACK_PORCH    = 220,
  parameter int ACTIVE_LINES    = 720,
  parameter int V_FRONT_PORCH   = 5,
  parameter int V_SYNC_WIDTH    = 5,
  parameter int V_BACK_PORCH    = 20,
  parameter int FC_WIDTH        = 6
) (
  input  logic                clk_in,
  input  logic                rst_in,
  output logic [10:0]         hcount_out,
  output logic [9:0]          vcount_out,
  output logic                hs_out,
  output logic                vs_out,
  output logic                ad_out,
  output logic                nf_out,
  output logic [FC_WIDTH-1:0] fc_out
);

  localparam int TOTAL_PIXELS =
    ACTIVE_H_PIXELS + H_FRONT_PORCH +
    H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int TOTAL_LINES =
    ACTIVE_LINES + V_FRONT_PORCH +
    V_SYNC_WIDTH + V_BACK_PORCH;

  localparam int HS_ON_I =
    ACTIVE_H_PIXELS + H_FRONT_PORCH;
  localparam int VS_ON_I =
    ACTIVE_LINES + V_FRONT_PORCH;

  localparam logic [10:0] H_LAST =
    11'(TOTAL_PIXELS - 1);
  localparam logic [9:0]  V_LAST =
    10'(TOTAL_LINES - 1);
  localparam logic [10:0] H_ACT  =
    11'(ACTIVE_H_PIXELS);
  localparam logic [9:0]  V_ACT  =
    10'(ACTIVE_LINES);
  localparam logic [10:0] HS_ON  =
    11'(HS_ON_I);
  localparam logic [10:0] HS_OFF =
    11'(HS_ON_I + H_SYNC_WIDTH);
  localparam logic [9:0]  VS_ON  =
    10'(VS_ON_I);
  localparam logic [9:0]  VS_OFF =
    10'(VS_ON_I + V_SYNC_WIDTH);

  // HOLD: first cycle out of reset presents (0,0) without advancing.
  typedef enum logic {
    ST_HOLD,
    ST_RUN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [10:0]         h_nxt;
  logic [9:0]          v_nxt;
  logic                hs_d;
  logic                vs_d;
  logic                ad_d;
  logic                nf_d;
  logic [FC_WIDTH-1:0] fc_d;

  // State register: reset parks the generator in HOLD.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= ST_HOLD;
    end else begin
      state_q <= state_d;
    end
  end

  // Next counts, next-state and decode of the next position.
  always_comb begin
    state_d = state_q;
    h_nxt   = hcount_out;
    v_nxt   = vcount_out;
    unique case (state_q)
      ST_HOLD: begin
        state_d = ST_RUN;
        h_nxt   = '0;
        v_nxt   = '0;
      end
      ST_RUN: begin
        if (hcount_out == H_LAST) begin
          h_nxt = '0;
          if (vcount_out == V_LAST) begin
            v_nxt = '0;
          end else begin
            v_nxt = vcount_out + 10'd1;
          end
        end else begin
          h_nxt = hcount_out + 11'd1;
        end
      end
      default: begin
        state_d = ST_HOLD;
      end
    endcase
    hs_d = (h_nxt >= HS_ON) && (h_nxt < HS_OFF);
    vs_d = (v_nxt >= VS_ON) && (v_nxt < VS_OFF);
    ad_d = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    nf_d = (h_nxt == H_ACT) && (v_nxt == V_ACT);
    fc_d = nf_out ? fc_out + 1'b1 : fc_out;
  end

  // Output registers, loaded together so decode has no skew.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      hcount_out <= '0;
      vcount_out <= '0;
      hs_out     <= 1'b0;
      vs_out     <= 1'b0;
      ad_out     <= 1'b0;
      nf_out     <= 1'b0;
      fc_out     <= '0;
    end else begin
      hcount_out <= h_nxt;
      vcount_out <= v_nxt;
      hs_out     <= hs_d;
      vs_out     <= vs_d;
      ad_out     <= ad_d;
      nf_out     <= nf_d;
      fc_out     <= fc_d;
    end
  end

endmodule

// File: tb/tb_video_sig_gen.sv
// Directed bench for video_sig_gen on a scaled raster
// (25 pixels x 12 lines) so many frames fit in a short run.
module tb_video_sig_gen;

  localparam int AH = 16;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 4;
  localparam int AV = 6;
  localparam int VF = 1;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int FCW = 6;

  logic           clk_in;
  logic           rst_in;
  logic [10:0]    hcount_out;
  logic [9:0]     vcount_out;
  logic           hs_out;
  logic           vs_out;
  logic           ad_out;
  logic           nf_out;
  logic [FCW-1:0] fc_out;

  int total;
  int bad;

  video_sig_gen #(
    .ACTIVE_H_PIXELS(AH),
    .H_FRONT_PORCH(HF),
    .H_SYNC_WIDTH(HS),
    .H_BACK_PORCH(HB),
    .ACTIVE_LINES(AV),
    .V_FRONT_PORCH(VF),
    .V_SYNC_WIDTH(VS),
    .V_BACK_PORCH(VB),
    .FC_WIDTH(FCW)
  ) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .hcount_out(hcount_out),
    .vcount_out(vcount_out),
    .hs_out(hs_out),
    .vs_out(vs_out),
    .ad_out(ad_out),
    .nf_out(nf_out),
    .fc_out(fc_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(
    input string tag,
    input int    obs,
    input int    exp
  );
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic chk_pos(
    input string tag,
    input int    h,
    input int    v
  );
    chk({tag, "_h"}, int'(hcount_out), h);
    chk({tag, "_v"}, int'(vcount_out), v);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_h"}, int'(hcount_out), 0);
    chk({tag, "_v"}, int'(vcount_out), 0);
    chk({tag, "_hs"}, int'(hs_out), 0);
    chk({tag, "_vs"}, int'(vs_out), 0);
    chk({tag, "_ad"}, int'(ad_out), 0);
    chk({tag, "_nf"}, int'(nf_out), 0);
    chk({tag, "_fc"}, int'(fc_out), 0);
  endtask

  initial begin
    int hs_n;
    int hs_first;
    int hs_last;
    int ad_n;
    int vs_n;
    int nf_n;
    int nf_h;
    int nf_v;
    int fc_at_nf;
    int fc_after;
    int bad_pos;
    bit seen;
    total = 0;
    bad   = 0;

    // Reset hold.
    rst_in = 1'b0;
    step(3);
    chk_zero("reset");

    // Release: first cycle shows (0,0) with ad high.
    rst_in = 1'b1;
    step(1);
    chk_pos("rel0", 0, 0);
    chk("rel0_ad", int'(ad_out), 1);
    chk("rel0_hs", int'(hs_out), 0);
    step(1);
    chk_pos("rel1", 1, 0);
    step(1);
    chk_pos("rel2", 2, 0);
    step(1);
    chk_pos("rel3", 3, 0);

    // Line wrap (24,0) -> (0,1).
    step(21);
    chk_pos("lend", 24, 0);
    chk("lend_hs", int'(hs_out), 0);
    step(1);
    chk_pos("lwrap", 0, 1);

    // One line: hs window 18..20, active 0..15.
    hs_n = 0;
    hs_first = -1;
    hs_last = -1;
    ad_n = 0;
    for (int i = 0; i < 25; i++) begin
      if (hs_out) begin
        hs_n++;
        if (hs_first < 0) hs_first = int'(hcount_out);
        hs_last = int'(hcount_out);
      end
      if (ad_out) ad_n++;
      step(1);
    end
    chk("hs_count", hs_n, 3);
    chk("hs_first", hs_first, 18);
    chk("hs_last", hs_last, 20);
    chk("ad_line", ad_n, 16);
    chk_pos("line2", 0, 2);

    // Frame wrap (24,11) -> (0,0); one nf already passed.
    step(249);
    chk_pos("fend", 24, 11);
    chk("fend_vs", int'(vs_out), 0);
    chk("fend_fc", int'(fc_out), 1);
    step(1);
    chk_pos("fwrap", 0, 0);
    chk("fwrap_ad", int'(ad_out), 1);

    // Whole frame statistics.
    vs_n = 0;
    ad_n = 0;
    nf_n = 0;
    nf_h = -1;
    nf_v = -1;
    fc_at_nf = -1;
    fc_after = -1;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (seen) begin
        fc_after = int'(fc_out);
        seen = 1'b0;
      end
      if (vs_out) vs_n++;
      if (ad_out) ad_n++;
      if (nf_out) begin
        nf_n++;
        nf_h = int'(hcount_out);
        nf_v = int'(vcount_out);
        fc_at_nf = int'(fc_out);
        seen = 1'b1;
      end
      step(1);
    end
    chk("vs_frame", vs_n, 50);
    chk("ad_frame", ad_n, 96);
    chk("nf_frame", nf_n, 1);
    chk("nf_h", nf_h, 16);
    chk("nf_v", nf_v, 6);
    chk("fc_at_nf", fc_at_nf, 1);
    chk("fc_after", fc_after, 2);

    // Run to fc=63, then wrap to 0 one cycle after nf.
    step(300 * 61);
    chk_pos("f63", 0, 0);
    chk("fc63", int'(fc_out), 63);
    step(166);
    chk_pos("nf63", 16, 6);
    chk("nf63_nf", int'(nf_out), 1);
    chk("nf63_fc", int'(fc_out), 63);
    step(1);
    chk_pos("wrap", 17, 6);
    chk("fc_wrap", int'(fc_out), 0);
    chk("wrap_nf", int'(nf_out), 0);

    // Mid-frame reset at (10,3) of the next frame.
    step(218);
    chk_pos("mid", 10, 3);
    chk("mid_ad", int'(ad_out), 1);
    rst_in = 1'b0;
    nf_n = 0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      if (nf_out) nf_n++;
    end
    chk_zero("mrst");
    chk("mrst_nf", nf_n, 0);
    rst_in = 1'b1;
    step(1);
    chk_pos("mrel0", 0, 0);
    chk("mrel0_ad", int'(ad_out), 1);
    chk("mrel0_fc", int'(fc_out), 0);
    step(1);
    chk_pos("mrel1", 1, 0);

    // Render start taken from nf over two frames.
    nf_n = 0;
    bad_pos = 0;
    for (int i = 0; i < 600; i++) begin
      if (nf_out) begin
        nf_n++;
        if (hcount_out != 11'd16) bad_pos++;
        if (vcount_out != 10'd6) bad_pos++;
      end
      step(1);
    end
    chk("render_starts", nf_n, 2);
    chk("render_pos", bad_pos, 0);
    chk("render_fc", int'(fc_out), 2);
    chk_pos("render_end", 1, 0);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule

// File: doc/video_sig_gen.md
Name: video_sig_gen

Overview:
- Video timing generator for the 1280x720@60 HDMI path.
- Runs on the pixel clock and produces the raster position (hcount_out/vcount_out) consumed by render and the pixel pipeline.
- Also produces sync, active-draw, new-frame and frame-count signals.
- new_frame_out is the render start strobe: it pulses at the first blanking pixel after the last active line.

Parameters:
ACTIVE_H_PIXELS, 1280, visible pixels per line
H_FRONT_PORCH, 110, pixels between end of active and hsync
H_SYNC_WIDTH, 40, hsync pulse width in pixels
H_BACK_PORCH, 220, pixels between hsync and next active line
ACTIVE_LINES, 720, visible lines per frame
V_FRONT_PORCH, 5, lines between end of active and vsync
V_SYNC_WIDTH, 5, vsync pulse width in lines
V_BACK_PORCH, 20, lines between vsync and next frame
FC_WIDTH, 6, frame counter width

Ports:
clk_in  input  1  pixel clock (74.25 MHz)
rst_in  input  1  synchronous reset, active-low (reset when rst_in==0 at rising edge of clk_in)
hcount_out  output  11  horizontal position, 0..TOTAL_PIXELS-1
vcount_out  output  10  vertical position, 0..TOTAL_LINES-1
hs_out  output  1  hsync, active-high
vs_out  output  1  vsync, active-high
ad_out  output  1  active draw: position is visible
nf_out  output  1  new frame / render start, one-cycle pulse
fc_out  output  FC_WIDTH  frame counter

Behaviour:
- Derived constants:
  - TOTAL_PIXELS = sum of the four H parameters (default 1650).
  - TOTAL_LINES = sum of the four V parameters (default 750).
  - Defaults must fit the 11/10-bit counters; generics exceeding 2047/1023 are unsupported.
- Counter rules:
  - hcount increments every cycle and wraps TOTAL_PIXELS-1 -> 0.
  - On that wrap, vcount increments and wraps TOTAL_LINES-1 -> 0.
  - Both wraps happen on the same edge at (TOTAL_PIXELS-1, TOTAL_LINES-1).
- Reset (rst_in==0 sampled at an edge):
  - Next state: hcount_out=0, vcount_out=0, fc_out=0, hs_out=0, vs_out=0, ad_out=0, nf_out=0.
  - Reset asserted mid-frame aborts the frame immediately; no nf_out pulse is generated by reset.
- First cycle after rst_in returns high:
  - Counts remain (0,0) for that cycle; decoded outputs reflect (0,0), so ad_out=1.
  - Counts then advance to (1,0) on the next edge.
- Decode: all outputs are registered and aligned with the hcount_out/vcount_out values presented in the same cycle; zero relative skew.
  - hs_out=1 iff ACTIVE_H_PIXELS+H_FRONT_PORCH <= hcount < ACTIVE_H_PIXELS+H_FRONT_PORCH+H_SYNC_WIDTH (default 1390..1429).
  - vs_out=1 iff ACTIVE_LINES+V_FRONT_PORCH <= vcount < ACTIVE_LINES+V_FRONT_PORCH+V_SYNC_WIDTH (default lines 725..729, whole lines).
  - ad_out=1 iff hcount < ACTIVE_H_PIXELS and vcount < ACTIVE_LINES.
  - nf_out=1 iff hcount==ACTIVE_H_PIXELS and vcount==ACTIVE_LINES (default 1280,720). Exactly one cycle per frame.
- fc_out:
  - Increments by 1 in the cycle after nf_out is high, i.e. the new value is visible alongside hcount 1281.
  - Wraps 2^FC_WIDTH-1 -> 0.
- Implementation: next-count values are computed combinationally and output registers are loaded from them, so decode stays aligned without a pipeline skew stage.

Test Plan:
- Reset hold, then release: while rst_in=0, all outputs 0. First cycle after release: (0,0), ad_out=1. Then hcount 1,2,3 on successive cycles.
- Line wrap: observe (1649,0) -> (0,1). hs_out high exactly 40 cycles per line, first at hcount 1390, last at 1429.
- Frame wrap: (1649,749) -> (0,0). vs_out high for exactly 5 lines (725..729), i.e. 8250 cycles. ad_out high for 921600 cycles per frame.
- nf_out: exactly one pulse per 1237500 cycles, at (1280,720). fc_out goes 0->1 one cycle later. Run 64 frames and confirm fc_out wraps 63->0.
- Mid-frame reset: assert rst_in=0 at (500,300) for 3 cycles. Outputs zero, no nf_out pulse, fc_out=0. After release, counting restarts from (0,0).
- Render hookup: drive render start_in from nf_out over 2 frames. Start seen once per frame at (1280,720), matching the expected render start condition.
